input_fm_pingpong_buffer: RTL and testbench

//  Banked, double-buffered input feature-map tile store between the DDR load path and the conv PE array.

---
 rtl/input_fm_pingpong_buffer_pkg.sv | 7 +
 rtl/input_fm_wr_agu.sv | 44 ++++
 rtl/input_fm_pingpong_buffer.sv | 101 ++++++++++
 tb/tb_input_fm_pingpong_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_fm_pingpong_buffer_pkg.sv
// input_fm_pingpong_buffer_pkg: set-state encoding and tile capacity helper for the ping-pong input buffer
package input_fm_pingpong_buffer_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} set_state_t;
  function automatic int tile_cap(input int tm, input int x, input int tr, input int tc);
    return (tm / x) * tr * tc;
  endfunction
endpackage

// File: rtl/input_fm_wr_agu.sv
// input_fm_wr_agu: col/row/chan write counters producing bank select, bank-local offset and last-word flag
module input_fm_wr_agu
  import input_fm_pingpong_buffer_pkg::*;
#(
  parameter int AW = 16,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int X  = 4,
  parameter int BW = (X > 1) ? $clog2(X) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [BW-1:0] bank,
  output logic [AW-1:0] offset,
  output logic          last
);
  localparam int CW = (Tc > 1) ? $clog2(Tc) : 1;
  localparam int RW = (Tr > 1) ? $clog2(Tr) : 1;
  localparam int HW = (Tm > 1) ? $clog2(Tm) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] chan;
  logic last_col, last_row, last_chan;
  assign last_col  = col == CW'(Tc - 1);
  assign last_row  = row == RW'(Tr - 1);
  assign last_chan = chan == HW'(Tm - 1);
  assign last      = last_col & last_row & last_chan;
  assign bank      = BW'(int'(chan) % X);
  assign offset    = AW'((int'(chan) / X) * (Tr * Tc) + int'(row) * Tc + int'(col));
  // col fastest, then row, then channel; everything wraps to zero after the last word of a tile
  always_ff @(posedge clk) begin
    if (!rst) begin
      col  <= '0;
      row  <= '0;
      chan <= '0;
    end else if (adv) begin
      col  <= last_col ? '0 : col + 1'b1;
      row  <= last_col ? (last_row ? '0 : row + 1'b1) : row;
      chan <= (last_col && last_row) ? (last_chan ? '0 : chan + 1'b1) : chan;
    end
  end
endmodule

// File: rtl/input_fm_pingpong_buffer.sv
// input_fm_pingpong_buffer: banked double-buffered input feature-map tile store; INPUT_FM_RD_REG_EN adds an rd_data output register
module input_fm_pingpong_buffer
  import input_fm_pingpong_buffer_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int Tm = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int X  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic            wr_tile_done,
  output logic            tile_ready,
  input  logic            tile_release,
  input  logic [AW-1:0]   rd_addr,
  output logic [X*DW-1:0] rd_data
);
  localparam int CAP   = tile_cap(Tm, X, Tr, Tc);
  localparam int DEPTH = 2 * CAP;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (X > 1) ? $clog2(X) : 1;
  set_state_t          st [2];
  logic                wr_sel, rd_sel;
  logic                accept, last, rel;
  logic [BW-1:0]       bank;
  logic [AW-1:0]       offset;
  logic                wr_en_q, done_q, done_set_q;
  logic [BW-1:0]       wr_bank_q;
  logic [PW-1:0]       wr_addr_q, rd_phys;
  logic [DW-1:0]       wr_data_q;
  logic [X*DW-1:0]     rd_raw;
  assign wr_ready     = st[wr_sel] != FULL;
  assign accept       = wr_valid & wr_ready;
  assign wr_tile_done = accept & last;
  assign tile_ready   = st[rd_sel] == FULL;
  assign rel          = tile_release & tile_ready;
  assign rd_phys      = PW'(int'(rd_addr) + (rd_sel ? CAP : 0));
  input_fm_wr_agu #(.AW(AW), .Tm(Tm), .Tr(Tr), .Tc(Tc), .X(X), .BW(BW)) u_agu (
    .clk    (clk),
    .rst    (rst),
    .adv    (accept),
    .bank   (bank),
    .offset (offset),
    .last   (last)
  );
  // set-state FSM plus write pipeline; a finished set turns FULL one edge after its last word so the RAM write has landed
  always_ff @(posedge clk) begin
    if (!rst) begin
      st[0]      <= EMPTY;
      st[1]      <= EMPTY;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      done_set_q <= 1'b0;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q    <= accept;
      wr_bank_q  <= bank;
      wr_addr_q  <= PW'(int'(offset) + (wr_sel ? CAP : 0));
      wr_data_q  <= wr_data;
      done_q     <= wr_tile_done;
      done_set_q <= wr_sel;
      if (accept && st[wr_sel] == EMPTY) st[wr_sel] <= FILLING;
      if (wr_tile_done) wr_sel <= ~wr_sel;
      if (done_q) st[done_set_q] <= FULL;
      if (rel) begin
        st[rd_sel] <= EMPTY;
        rd_sel     <= ~rd_sel;
      end
    end
  end
  for (genvar k = 0; k < X; k++) begin : gen_bank
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;
    // bank RAM write from the pipeline register; contents survive reset
    always_ff @(posedge clk) begin
      if (wr_en_q && wr_bank_q == BW'(k)) mem[wr_addr_q] <= wr_data_q;
    end
    // registered RAM read from the current read set
    always_ff @(posedge clk) begin
      q <= !rst ? '0 : mem[rd_phys];
    end
    assign rd_raw[k*DW +: DW] = q;
  end
`ifdef INPUT_FM_RD_REG_EN
  // optional extra output stage for timing
  always_ff @(posedge clk) begin
    rd_data <= !rst ? '0 : rd_raw;
  end
`else
  assign rd_data = rd_raw;
`endif
endmodule

// File: tb/tb_input_fm_pingpong_buffer.sv
// tb_input_fm_pingpong_buffer: directed scenario bench for the ping-pong input buffer (Tm=4, Tr=2, Tc=2, X=2)
module tb_input_fm_pingpong_buffer;
  localparam int AW = 3;
  localparam int DW = 32;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready, wr_tile_done, tile_ready;
  logic            tile_release = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic [2*DW-1:0] rd_data;
  int              checks = 0;
  int              errors = 0;
  int              done_cnt;
  logic            done_last;
  logic [2*DW-1:0] q;

  input_fm_pingpong_buffer #(.AW(AW), .DW(DW), .Tm(4), .Tr(2), .Tc(2), .X(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_tile_done (wr_tile_done),
    .tile_ready   (tile_ready),
    .tile_release (tile_release),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    wr_valid     = v;
    wr_data      = d;
    tile_release = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic rst_on();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    tile_release = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_off();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic stream(input int base, input int n, input logic rel_last);
    int i = 0;
    int budget = 0;
    done_cnt  = 0;
    done_last = 1'b0;
    while (i < n && budget < 64) begin
      cyc(1'b1, DW'(base + i), rel_last && i == n - 1);
      budget++;
      if (wr_ready) begin
        if (wr_tile_done) done_cnt++;
        if (i == n - 1) done_last = wr_tile_done;
        i++;
      end
    end
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL stream_budget: accepted %0d of %0d words", i, n);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [2*DW-1:0] v);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    tile_release = 1'b0;
    rd_addr = a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic test_reset();
    rst_on();
    checks += 4;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    if (wr_tile_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", wr_tile_done); end
    if (tile_ready !== 1'b0) begin errors++; $display("FAIL reset_tile_ready: got %b want 0", tile_ready); end
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    rst_off();
  endtask

  task automatic test_single_tile();
    rst_on();
    rst_off();
    stream(0, 16, 1'b0);
    checks += 2;
    if (done_cnt !== 1) begin errors++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt); end
    if (done_last !== 1'b1) begin errors++; $display("FAIL t1_done_last: got %b want 1", done_last); end
    idle(1);
    checks++;
    if (tile_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_t1: got %b want 0", tile_ready); end
    idle(1);
    checks++;
    if (tile_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_t2: got %b want 1", tile_ready); end
    rd(3'd0, q);
    checks++;
    if (q !== {32'd4, 32'd0}) begin errors++; $display("FAIL t1_rd0: got %h want %h", q, {32'd4, 32'd0}); end
    rd(3'd3, q);
    checks++;
    if (q !== {32'd7, 32'd3}) begin errors++; $display("FAIL t1_rd3: got %h want %h", q, {32'd7, 32'd3}); end
    rd(3'd5, q);
    checks++;
    if (q !== {32'd13, 32'd9}) begin errors++; $display("FAIL t1_rd5: got %h want %h", q, {32'd13, 32'd9}); end
    rd(3'd7, q);
    checks++;
    if (q !== {32'd15, 32'd11}) begin errors++; $display("FAIL t1_rd7: got %h want %h", q, {32'd15, 32'd11}); end
  endtask

  task automatic test_back_to_back();
    rst_on();
    rst_off();
    stream(100, 16, 1'b0);
    stream(200, 16, 1'b0);
    checks++;
    if (done_last !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", done_last); end
    idle(1);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", wr_ready); end
    for (int j = 0; j < 3; j++) begin
      cyc(1'b1, 32'hdead_0000 + DW'(j), 1'b0);
      checks++;
      if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready%0d: got %b want 0", j, wr_ready); end
    end
    cyc(1'b0, '0, 1'b1);
    idle(1);
    checks += 2;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_rel_ready: got %b want 1", wr_ready); end
    if (tile_ready !== 1'b1) begin errors++; $display("FAIL b2b_set1_ready: got %b want 1", tile_ready); end
    rd(3'd0, q);
    checks++;
    if (q !== {32'd204, 32'd200}) begin errors++; $display("FAIL b2b_rd_set1: got %h want %h", q, {32'd204, 32'd200}); end
    stream(300, 16, 1'b0);
    checks += 2;
    if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_cnt3: got %0d want 1", done_cnt); end
    if (done_last !== 1'b1) begin errors++; $display("FAIL b2b_done3: got %b want 1", done_last); end
    idle(2);
    cyc(1'b0, '0, 1'b1);
    idle(2);
    checks++;
    if (tile_ready !== 1'b1) begin errors++; $display("FAIL b2b_set0_ready: got %b want 1", tile_ready); end
    rd(3'd6, q);
    checks++;
    if (q !== {32'd314, 32'd310}) begin errors++; $display("FAIL b2b_rd_set0: got %h want %h", q, {32'd314, 32'd310}); end
  endtask

  task automatic test_release_on_last();
    rst_on();
    rst_off();
    stream(400, 16, 1'b0);
    idle(2);
    stream(500, 16, 1'b1);
    checks++;
    if (done_last !== 1'b1) begin errors++; $display("FAIL rol_done: got %b want 1", done_last); end
    idle(1);
    checks += 2;
    if (tile_ready !== 1'b0) begin errors++; $display("FAIL rol_ready_t1: got %b want 0", tile_ready); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL rol_wr_ready: got %b want 1", wr_ready); end
    idle(1);
    checks++;
    if (tile_ready !== 1'b1) begin errors++; $display("FAIL rol_ready_t2: got %b want 1", tile_ready); end
    rd(3'd1, q);
    checks++;
    if (q !== {32'd505, 32'd501}) begin errors++; $display("FAIL rol_rd1: got %h want %h", q, {32'd505, 32'd501}); end
  endtask

  task automatic test_ignored_release();
    rst_on();
    rst_off();
    cyc(1'b0, '0, 1'b1);
    idle(1);
    checks += 2;
    if (tile_ready !== 1'b0) begin errors++; $display("FAIL ign_tile_ready: got %b want 0", tile_ready); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL ign_wr_ready: got %b want 1", wr_ready); end
    stream(600, 5, 1'b0);
    cyc(1'b0, '0, 1'b1);
    stream(605, 11, 1'b0);
    checks++;
    if (done_last !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", done_last); end
    idle(2);
    checks++;
    if (tile_ready !== 1'b1) begin errors++; $display("FAIL ign_ready: got %b want 1", tile_ready); end
    rd(3'd0, q);
    checks++;
    if (q !== {32'd604, 32'd600}) begin errors++; $display("FAIL ign_rd0: got %h want %h", q, {32'd604, 32'd600}); end
  endtask

  task automatic test_mid_tile_reset();
    rst_on();
    rst_off();
    stream(700, 7, 1'b0);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL mtr_partial_done: got %0d want 0", done_cnt); end
    rst_on();
    checks += 4;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL mtr_wr_ready: got %b want 1", wr_ready); end
    if (wr_tile_done !== 1'b0) begin errors++; $display("FAIL mtr_done: got %b want 0", wr_tile_done); end
    if (tile_ready !== 1'b0) begin errors++; $display("FAIL mtr_tile_ready: got %b want 0", tile_ready); end
    if (rd_data !== '0) begin errors++; $display("FAIL mtr_rd_data: got %h want 0", rd_data); end
    rst_off();
    stream(800, 16, 1'b0);
    checks++;
    if (done_last !== 1'b1) begin errors++; $display("FAIL mtr_new_done: got %b want 1", done_last); end
    idle(2);
    checks++;
    if (tile_ready !== 1'b1) begin errors++; $display("FAIL mtr_ready: got %b want 1", tile_ready); end
    rd(3'd7, q);
    checks++;
    if (q !== {32'd815, 32'd811}) begin errors++; $display("FAIL mtr_rd7: got %h want %h", q, {32'd815, 32'd811}); end
    rd(3'd0, q);
    checks++;
    if (q !== {32'd804, 32'd800}) begin errors++; $display("FAIL mtr_rd0: got %h want %h", q, {32'd804, 32'd800}); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_release_on_last();
    test_ignored_release();
    test_mid_tile_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
